// File: rtl/code_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package code_loader_pkg;

  localparam int          WORDS_DEF    = 1024;
  localparam int          WORD_W_DEF   = 32;
  localparam int          IMG_W        = WORDS_DEF * WORD_W_DEF;
  localparam logic [1:0]  TRIT_RST     = 2'b00;
  localparam logic [1:0]  RUN_CODE_DEF = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

endpackage

// File: rtl/code_image.sv
// Flat instruction image register array: bulk clear plus one word write per cycle.
module code_image #(
  parameter int WORDS  = 1024,
  parameter int WORD_W = 32,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [WORD_W-1:0]         wr_data,
  output logic [WORDS*WORD_W-1:0]   input_code
);

  // Packed so word k lands at bits [k*WORD_W +: WORD_W] of the flat output.
  logic [WORDS-1:0][WORD_W-1:0] mem;

  // NOTE: this array is reset on purpose: the CPU must never see stale code,
  // and unwritten words are defined as zero, so it cannot be a plain RAM.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign input_code = mem;

endmodule

// File: rtl/code_loader.sv
// Loads a program over valid/ready into the CPU code image and sequences the CPU's ternary reset.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int         WORDS       = WORDS_DEF,
  parameter int         WORD_W      = WORD_W_DEF,
  parameter int         HOLD_CYCLES = 8,
  parameter logic [1:0] RUN_CODE    = RUN_CODE_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_req,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic [WORDS*WORD_W-1:0]     input_code,
  output logic [1:0]                  cpu_rst_n,
  output logic                        busy,
  output logic                        running,
  output logic [$clog2(WORDS):0]      word_count
);

  localparam int                IDX_W     = $clog2(WORDS);
  localparam int                CNT_W     = IDX_W + 1;
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state, next_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                accept;
  logic                last_slot;
  logic                img_clear;
  logic                img_wr;

  assign in_ready  = (state == ST_LOAD);
  assign running   = (state == ST_RUN);
  assign busy      = (state == ST_CLEAR) || (state == ST_LOAD) || (state == ST_HOLD);
  assign cpu_rst_n = running ? RUN_CODE : TRIT_RST;

  assign accept    = in_valid && in_ready;
  assign last_slot = (word_count == CNT_W'(WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    img_clear  = 1'b0;
    img_wr     = 1'b0;
    unique case (state)
      ST_IDLE:  if (load_req) next_state = ST_CLEAR;
      ST_CLEAR: begin
        img_clear  = 1'b1;
        next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          img_wr = 1'b1;
          if (in_last || last_slot) next_state = ST_HOLD;
        end
      end
      ST_HOLD:  if (hold_cnt == '0) next_state = ST_RUN;
      ST_RUN:   if (load_req) next_state = ST_CLEAR;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Word counter doubles as the write index; the hold counter is armed on LOAD exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= '0;
      hold_cnt   <= '0;
    end else begin
      if (state == ST_CLEAR) begin
        word_count <= '0;
      end else if (img_wr) begin
        word_count <= word_count + 1'b1;
      end

      if (state == ST_LOAD && next_state == ST_HOLD) begin
        hold_cnt <= HOLD_INIT;
      end else if (state == ST_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  code_image #(
    .WORDS  (WORDS),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_image (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (img_clear),
    .wr_en      (img_wr),
    .wr_idx     (word_count[IDX_W-1:0]),
    .wr_data    (in_data),
    .input_code (input_code)
  );

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader: reset, loads with gaps, full image, reload, mid-load reset.
module tb_code_loader;
  import code_loader_pkg::*;

  localparam int WORDS  = 1024;
  localparam int WORD_W = 32;
  localparam int HOLD   = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    load_req = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WORD_W-1:0]       in_data = '0;
  logic                    in_last = 1'b0;
  logic [IMG_W-1:0]        input_code;
  logic [1:0]              cpu_rst_n;
  logic                    busy;
  logic                    running;
  logic [$clog2(WORDS):0]  word_count;

  logic [IMG_W-1:0]        exp_img;
  int                      checks = 0;
  int                      errors = 0;

  always #5 clk = ~clk;

  code_loader #(
    .WORDS       (WORDS),
    .WORD_W      (WORD_W),
    .HOLD_CYCLES (HOLD),
    .RUN_CODE    (2'b10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .input_code (input_code),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .running    (running),
    .word_count (word_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Index of the first image word differing from the bench's expected image, or -1.
  function automatic int first_diff();
    for (int k = 0; k < WORDS; k++) begin
      if (input_code[k*WORD_W +: WORD_W] !== exp_img[k*WORD_W +: WORD_W]) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int k = 0; k < 40 && !running; k++) tick();
    check(tag, running, 1'b1);
  endtask

  logic [WORD_W-1:0] gap_data  [6];
  logic              gap_valid [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_img = '0;

    // Reset held for two cycles.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_cpu_rst", cpu_rst_n, TRIT_RST);
    check("rst_img", first_diff(), -1);
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_count", word_count, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // Basic three-word load.
    pulse_load();
    check("clr_busy", busy, 1'b1);
    check("clr_ready", in_ready, 1'b0);
    tick();
    check("load_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {4{4'(i + 1), 4'(i + 1)}};
      in_last  = (i == 2);
      exp_img[i*WORD_W +: WORD_W] = in_data;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("basic_ready_after", in_ready, 1'b0);
    check("basic_busy_after", busy, 1'b1);
    check("basic_count", word_count, 3);
    check("basic_lo96", input_code[95:0], 96'h333333332222222211111111);
    check("basic_img", first_diff(), -1);
    begin
      int k;
      for (k = 1; k <= 20; k++) begin
        tick();
        if (cpu_rst_n == 2'b10) break;
      end
      check("hold_edges", k, HOLD);
    end
    check("run_running", running, 1'b1);
    check("run_busy", busy, 1'b0);

    // Gapped beats; a load_req during LOAD must be ignored.
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    gap_data  = '{32'hA0A0_0001, 32'hDEAD_0BAD, 32'hDEAD_0BAD,
                  32'hB0B0_0002, 32'hDEAD_0BAD, 32'hC0C0_0003};
    pulse_load();
    check("gap_cpu_rst", cpu_rst_n, TRIT_RST);
    tick();
    exp_img = '0;
    exp_img[0*WORD_W +: WORD_W] = 32'hA0A0_0001;
    exp_img[1*WORD_W +: WORD_W] = 32'hB0B0_0002;
    exp_img[2*WORD_W +: WORD_W] = 32'hC0C0_0003;
    for (int i = 0; i < 6; i++) begin
      in_valid = gap_valid[i];
      in_data  = gap_data[i];
      in_last  = (i == 5);
      load_req = (i == 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    load_req = 1'b0;
    check("gap_count", word_count, 3);
    check("gap_img", first_diff(), -1);
    wait_run("gap_run");

    // Full image, no in_last: loader must leave LOAD after the last slot.
    pulse_load();
    tick();
    exp_img = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == WORDS - 1) check("full_ready_last", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = WORD_W'(i + 1);
      exp_img[i*WORD_W +: WORD_W] = WORD_W'(i + 1);
      tick();
    end
    check("full_ready_after", in_ready, 1'b0);
    check("full_busy_after", busy, 1'b1);
    check("full_count", word_count, 1024);
    check("full_w1023", input_code[1023*WORD_W +: WORD_W], 32'h0000_0400);
    in_data = 32'hFFFF_FFFF;
    tick();
    tick();
    in_valid = 1'b0;
    check("full_no_overflow_cnt", word_count, 1024);
    check("full_img", first_diff(), -1);
    wait_run("full_run");

    // Reload from RUN: reset asserted at once, image cleared one cycle later.
    pulse_load();
    check("reload_cpu_rst", cpu_rst_n, TRIT_RST);
    check("reload_running", running, 1'b0);
    tick();
    exp_img = '0;
    check("reload_img_clear", first_diff(), -1);
    check("reload_count_clear", word_count, 0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    exp_img[WORD_W-1:0] = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("reload_img", first_diff(), -1);
    check("reload_count", word_count, 1);
    wait_run("reload_run");

    // Reset mid-LOAD after five beats; load_req ignored while reset held.
    pulse_load();
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = WORD_W'(32'h5000 + i);
      tick();
    end
    in_valid = 1'b0;
    check("mid_count_pre", word_count, 5);
    rst_n = 1'b0;
    tick();
    exp_img = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_cpu", cpu_rst_n, TRIT_RST);
    check("mid_rst_img", first_diff(), -1);
    check("mid_rst_count", word_count, 0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("rst_wins_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 1'b0);
    pulse_load();
    check("post_rst_load", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
